// File: rtl/logic_capture_buffer.sv
// Four-channel logic capture store: divided sample clock, pre/post-trigger
// sequencing into a circular RAM, and a one-cycle registered column read port.
module logic_capture_buffer #(
   parameter int DEPTH    = 88,
   parameter int X_OFFSET = 8,
   parameter int PRE_TRIG = 8,
   parameter int DIV_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       ch_in,
   input  logic [DIV_W-1:0] sample_div,
   input  logic             arm,
   input  logic [1:0]       trig_ch,
   input  logic             trig_rise,
   input  logic             force_trig,
   input  logic [6:0]       x,
   output logic [3:0]       sample,
   output logic             busy,
   output logic             triggered,
   output logic             done
);

   localparam int AW     = $clog2(DEPTH);
   localparam int POST_N = DEPTH - PRE_TRIG - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRETRIG,
      S_WAIT_TRIG,
      S_POST,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       ch_s1_q, ch_s2_q;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [DIV_W-1:0] period_q, period_d, period_eff;
   logic             tick;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, wr_ptr_inc;
   logic [AW-1:0]    start_ptr_q, start_ptr_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic [3:0]       prev_q, prev_d;
   logic             we;
   logic             trig_edge;
   logic [3:0]       mem [DEPTH];
   logic [7:0]       x_ext, x_rel;
   logic             in_win;
   logic [AW-1:0]    rd_idx;

   // Addition modulo DEPTH for operands already below DEPTH.
   function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
      logic [AW:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= (AW+1)'(DEPTH)) mod_add = AW'(sum - (AW+1)'(DEPTH));
      else                       mod_add = AW'(sum);
   endfunction

   assign busy      = (state_q == S_PRETRIG) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);
   assign triggered = (state_q == S_POST) || (state_q == S_DONE);
   assign done      = (state_q == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_s1_q <= '0;
         ch_s2_q <= '0;
      end else begin
         ch_s1_q <= ch_in;
         ch_s2_q <= ch_s1_q;
      end
   end

   // The period is latched only at a wrap or on arm, so a new sample_div
   // never truncates or stretches the period already in progress.
   assign period_eff = (sample_div == '0) ? DIV_W'(1) : sample_div;
   assign tick       = (div_cnt_q == period_q - DIV_W'(1));

   always_comb begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
      period_d  = period_q;
      if (arm || tick) begin
         div_cnt_d = '0;
         period_d  = period_eff;
      end
   end

   assign wr_ptr_inc = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
   assign trig_edge  = trig_rise ? (!prev_q[trig_ch] &&  ch_s2_q[trig_ch])
                                 : ( prev_q[trig_ch] && !ch_s2_q[trig_ch]);

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      start_ptr_d = start_ptr_q;
      cnt_d       = cnt_q;
      prev_d      = prev_q;
      we          = 1'b0;
      if (arm) begin
         state_d  = S_PRETRIG;
         wr_ptr_d = '0;
         cnt_d    = '0;
      end else if (tick && busy) begin
         we       = 1'b1;
         wr_ptr_d = wr_ptr_inc;
         prev_d   = ch_s2_q;
         case (state_q)
            S_PRETRIG: begin
               if (cnt_q == AW'(PRE_TRIG - 1)) begin
                  state_d = S_WAIT_TRIG;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + AW'(1);
               end
            end
            S_WAIT_TRIG: begin
               if (trig_edge || force_trig) begin
                  // Window start sits PRE_TRIG samples behind the trigger write.
                  start_ptr_d = mod_add(wr_ptr_q, AW'(DEPTH - PRE_TRIG));
                  cnt_d       = '0;
                  state_d     = (POST_N == 0) ? S_DONE : S_POST;
               end
            end
            S_POST: begin
               if (cnt_q == AW'(POST_N - 1)) state_d = S_DONE;
               else                          cnt_d   = cnt_q + AW'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         div_cnt_q   <= '0;
         period_q    <= DIV_W'(1);
         wr_ptr_q    <= '0;
         start_ptr_q <= '0;
         cnt_q       <= '0;
         prev_q      <= '0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         period_q    <= period_d;
         wr_ptr_q    <= wr_ptr_d;
         start_ptr_q <= start_ptr_d;
         cnt_q       <= cnt_d;
         prev_q      <= prev_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[wr_ptr_q] <= ch_s2_q;
   end

   assign x_ext  = {1'b0, x};
   assign x_rel  = x_ext - 8'(X_OFFSET);
   assign in_win = (x_ext >= 8'(X_OFFSET)) && (x_ext < 8'(X_OFFSET + DEPTH));
   assign rd_idx = mod_add(start_ptr_q, AW'(x_rel));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              sample <= '0;
      else if (done && in_win) sample <= mem[rd_idx];
      else                     sample <= '0;
   end

endmodule
